zprize_div_seq: RTL and testbench
=================================

// Module: zprize_div_seq
// PURPOSE
//  Sequential restoring divider: the inverse of the Karatsuba multiplier tree.
//  Takes a WD-bit dividend (a multiplier-width product) and a W-bit divisor, and returns the quotient and remainder.
//  It retires B quotient bits per cycle behind valid/ready handshakes.
//  It carries an M-bit sideband tag alongside each operation.
//  It serves as the host-side check path and handles slow-path reduction, where the dividend is an out0 product.
// PARAMETERS
//  W   384    divisor/remainder width
//  WD  2*W    dividend/quotient width; WD % B == 0 required
//  B   1      quotient bits retired per cycle (1 or 2)
//  M   32     sideband tag width, passed through unmodified
// PORTS
//  clk        in   1    single clock
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    dividend/divisor/m_i valid
//  in_ready   out  1    block can accept an operation
//  dividend   in   WD   numerator
//  divisor    in   W    denominator
//  m_i        in   M    tag, captured on accept
//  out_valid  out  1    result valid; held until out_ready
//  out_ready  in   1    consumer accepts the result
//  quotient   out  WD   floor(dividend/divisor)
//  remainder  out  W    dividend mod divisor
//  div0       out  1    divisor was zero
//  m_o        out  M    tag of the operation now presented
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0; quotient, remainder, div0 and m_o are all 0.
//    Reset acts immediately (asynchronous), including mid-operation; the operation in flight is discarded.
//  - FSM IDLE->RUN->DONE.
//    - IDLE: in_ready=1. On in_valid, latch the operands and tag, set cnt=ITER=WD/B, clear P, go to RUN.
//    - RUN: in_ready=0. Each cycle performs B steps, then cnt-=1; at cnt==1 go to DONE.
//    - DONE: out_valid=1 and outputs stay stable.
//      - out_ready=1 and in_valid=0: go to IDLE.
//      - out_ready=1 and in_valid=1: accept the new operation in the same cycle and go to RUN (in_ready = out_ready in DONE).
//      - out_ready=0: hold.
//  - Latency: out_valid rises exactly ITER+1 cycles after the accept edge. Latency is fixed and does not depend on the data, including for div0.
//  - Step: P is W+1 bits, seeded 0. Each step:
//    - P = {P[W-1:0], next dividend MSB}.
//    - If P >= {1'b0,divisor}: P -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
//    - Quotient bits shift in MSB-first.
//  - Result: remainder = P[W-1:0], guaranteed < divisor.
//  - divisor==0: div0=1, quotient = all ones, remainder = dividend[W-1:0]. Same latency as a normal operation.
//  - Throughput: one operation per ITER+1 cycles at best. There is no internal queue.
//  - No X on any output at any time after reset.
// STRUCTURE
//  - zprize_div_pkg holds:
//    - typedef enum {IDLE,RUN,DONE} div_state_t
//    - function div_iter(WD,B) = WD/B
//    - localparam CNT_W = $clog2(ITER+1)
//  - Sub-module zprize_div_step: one combinational radix-2 step, signature (P_in, dbit, divisor) -> (P_out, qbit).
//    It is instantiated B times in a chain inside the RUN datapath.
//  - Top level: FSM, counter, operand/quotient shift registers, output registers, tag register.
// TESTING (W=8, WD=16; run with B=1 and B=2)
//  1. dividend=0x1234, divisor=0x56 -> quotient=0x0036, remainder=0x10, div0=0; out_valid 17 cycles after accept (B=1), 9 cycles (B=2).
//  2. dividend=0xFFFF, divisor=0x01 -> quotient=0xFFFF, remainder=0x00. Also dividend=0x00FF, divisor=0xFF -> quotient=0x0001, remainder=0x00.
//  3. dividend=0xABCD, divisor=0x00, m_i=0xCAFE -> div0=1, quotient=0xFFFF, remainder=0xCD, m_o=0xCAFE; same latency as case 1.
//  4. Backpressure:
//     - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     - Then out_ready=1 with in_valid=1 -> new operation accepted that cycle; its result appears ITER+1 cycles later.
//  5. Reset mid-operation: assert rst at RUN iteration 7 -> out_valid=0 and all outputs 0 immediately; in_ready=1 after rst falls; the next operation (case 1) is correct.
//  6. Round-trip against zprize_mul with random a,b (b!=0), c<b, W=384: dividend = a*b + c -> quotient=a, remainder=c. Run 10k vectors with random valid/ready gaps.

Source files
------------

// File: rtl/zprize_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package zprize_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int div_iter(input int wd, input int b);
    return wd / b;
  endfunction

  // Width of the iteration counter (CNT_W), which must hold the value ITER itself.
  function automatic int div_cnt_w(input int wd, input int b);
    return $clog2(div_iter(wd, b) + 1);
  endfunction

endpackage

// File: rtl/zprize_div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module zprize_div_step #(
  parameter int W = 384
) (
  input  logic [W-1:0] p_in,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] p_out,
  output logic         qbit
);

  logic [W:0] shifted;

  assign shifted = {p_in, dbit};

  // When the subtraction is taken the true difference is below the divisor,
  // so the modular W-bit difference is exact.
  always_comb begin
    qbit  = (shifted >= {1'b0, divisor});
    p_out = qbit ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
  end

endmodule

// File: rtl/zprize_div_seq.sv
// Sequential restoring divider retiring B quotient bits per cycle, with a pass-through tag.
module zprize_div_seq
  import zprize_div_pkg::*;
#(
  parameter int W  = 384,
  parameter int WD = 2 * W,
  parameter int B  = 1,
  parameter int M  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] dividend,
  input  logic [W-1:0]  divisor,
  input  logic [M-1:0]  m_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] quotient,
  output logic [W-1:0]  remainder,
  output logic          div0,
  output logic [M-1:0]  m_o,
  output logic [1:0]    state
);

  localparam int ITER  = div_iter(WD, B);
  localparam int CNT_W = div_cnt_w(WD, B);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // valid never waits on ready, and out_valid with its data holds until out_ready.

  div_state_t       st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [WD-1:0]    sh;
  logic [WD-1:0]    sh_next;
  logic [W-1:0]     dsr;
  logic [W-1:0]     p;
  logic [M-1:0]     tag;
  logic [W-1:0]     p_chain [B+1];
  logic [B-1:0]     qbits;
  logic             accept;
  logic             last;

  assign p_chain[0] = p;

  // Dividend bits leave sh at the top while quotient bits enter at the bottom.
  for (genvar i = 0; i < B; i++) begin : g_step
    zprize_div_step #(.W(W)) u_step (
      .p_in    (p_chain[i]),
      .dbit    (sh[WD-1-i]),
      .divisor (dsr),
      .p_out   (p_chain[i+1]),
      .qbit    (qbits[B-1-i])
    );
  end

  assign sh_next   = {sh[WD-B-1:0], qbits};
  assign last      = (cnt == CNT_W'(1));
  assign accept    = in_valid & in_ready;
  assign out_valid = (st == DONE);
  assign state     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt      = st;
    in_ready = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = RUN;
      end
      RUN: begin
        if (last) nxt = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) nxt = in_valid ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sh        <= '0;
      dsr       <= '0;
      p         <= '0;
      tag       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      m_o       <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(ITER);
      sh  <= dividend;
      dsr <= divisor;
      p   <= '0;
      tag <= m_i;
    end else if (st == RUN) begin
      cnt <= cnt - CNT_W'(1);
      sh  <= sh_next;
      p   <= p_chain[B];
      // A zero divisor needs no special path: every trial subtract succeeds,
      // giving an all-ones quotient and the low dividend bits as remainder.
      if (last) begin
        quotient  <= sh_next;
        remainder <= p_chain[B];
        div0      <= (dsr == '0);
        m_o       <= tag;
      end
    end
  end

endmodule

// File: tb/tb_zprize_div_seq.sv
// Directed bench for zprize_div_seq, run side by side on a B=1 and a B=2 instance.
module tb_zprize_div_seq;

  localparam int W  = 8;
  localparam int WD = 16;
  localparam int M  = 16;
  localparam int EW = 1 + WD + W + M;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          div0      [2];
  logic [WD-1:0] dividend  [2];
  logic [WD-1:0] quotient  [2];
  logic [W-1:0]  divisor   [2];
  logic [W-1:0]  remainder [2];
  logic [M-1:0]  m_i       [2];
  logic [M-1:0]  m_o       [2];
  logic [1:0]    state     [2];

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  zprize_div_seq #(.W(W), .WD(WD), .B(1), .M(M)) u_div_b1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]), .m_i(m_i[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]),
    .div0(div0[0]), .m_o(m_o[0]), .state(state[0])
  );

  zprize_div_seq #(.W(W), .WD(WD), .B(2), .M(M)) u_div_b2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]), .m_i(m_i[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]),
    .div0(div0[1]), .m_o(m_o[1]), .state(state[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Latency counted in cycles from presenting the operation (accept cycle included) to out_valid.
  function automatic int lat_of(input int d);
    return (d == 0) ? 17 : 9;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic collect(input int d, input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_out_valid"}, out_valid[d], 1);
    check({tag, "_quotient"}, quotient[d], e[W+M +: WD]);
    check({tag, "_remainder"}, remainder[d], e[M +: W]);
    check({tag, "_div0"}, div0[d], e[EW-1]);
    check({tag, "_m_o"}, m_o[d], e[M-1:0]);
  endtask

  // ---------------- drivers ----------------
  task automatic wait_result(input int d, input int first, input string tag);
    int lat;
    lat = first;
    while (!out_valid[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_of(d));
  endtask

  // Called 1 time unit after a rising edge, with the instance idle.
  task automatic run_op(input int d, input logic [WD-1:0] a, input logic [W-1:0] b,
                        input logic [M-1:0] t, input logic [WD-1:0] eq,
                        input logic [W-1:0] er, input string tag);
    exp_q.push_back({(b == '0), eq, er, t});
    check({tag, "_in_ready"}, in_ready[d], 1);
    in_valid[d] = 1'b1;
    dividend[d] = a;
    divisor[d]  = b;
    m_i[d]      = t;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    wait_result(d, 1, tag);
    collect(d, tag);
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check("drain_out_valid", out_valid[d], 0);
  endtask

  // ---------------- stimulus ----------------
  logic [WD-1:0] va [7] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h0005, 16'hFFFF, 16'h8000, 16'hFFFE};
  logic [W-1:0]  vb [7] = '{8'h56,    8'h01,    8'hFF,    8'h07,    8'hFF,    8'h80,    8'hFF};
  logic [WD-1:0] vq [7] = '{16'h0036, 16'hFFFF, 16'h0001, 16'h0000, 16'h0101, 16'h0100, 16'h0100};
  logic [W-1:0]  vr [7] = '{8'h10,    8'h00,    8'h00,    8'h05,    8'h00,    8'h00,    8'hFE};

  task automatic run_suite(input int d);
    logic [WD-1:0] a;
    logic [W-1:0]  b;
    for (int i = 0; i < 7; i++) begin
      run_op(d, va[i], vb[i], M'(16'h0100 + i), vq[i], vr[i], $sformatf("dut%0d_vec%0d", d, i));
      drain(d);
    end

    run_op(d, 16'hABCD, 8'h00, 16'hCAFE, 16'hFFFF, 8'hCD, $sformatf("dut%0d_div0", d));
    drain(d);

    for (int i = 0; i < 10; i++) begin
      a = WD'($urandom_range(0, 65535));
      b = W'($urandom_range(1, 255));
      run_op(d, a, b, M'($urandom_range(0, 65535)), WD'(a / b), W'(a % b),
             $sformatf("dut%0d_rnd%0d", d, i));
      drain(d);
    end

    // Backpressure: result must hold while out_ready stays low.
    run_op(d, 16'h00FF, 8'hFF, 16'h0001, 16'h0001, 8'h00, $sformatf("dut%0d_bp", d));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid[d], 1);
      check("bp_in_ready", in_ready[d], 0);
      check("bp_quotient", quotient[d], 16'h0001);
      check("bp_m_o", m_o[d], 16'h0001);
    end
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    dividend[d]  = 16'h1234;
    divisor[d]   = 8'h56;
    m_i[d]       = 16'h0002;
    exp_q.push_back({1'b0, 16'h0036, 8'h10, 16'h0002});
    #1;
    check("bp_in_ready_follows_out_ready", in_ready[d], 1);
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    check("bp_state_run", state[d], 1);
    wait_result(d, 1, $sformatf("dut%0d_bp2", d));
    collect(d, $sformatf("dut%0d_bp2", d));
    drain(d);

    // Reset in the middle of RUN discards the operation.
    in_valid[d] = 1'b1;
    dividend[d] = 16'h1234;
    divisor[d]  = 8'h56;
    m_i[d]      = 16'h0003;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid[d], 0);
    check("mid_rst_quotient", quotient[d], 0);
    check("mid_rst_remainder", remainder[d], 0);
    check("mid_rst_m_o", m_o[d], 0);
    check("mid_rst_state", state[d], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready[d], 1);
    run_op(d, 16'h1234, 8'h56, 16'h0004, 16'h0036, 8'h10, $sformatf("dut%0d_post_rst", d));
    drain(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      dividend[d]  = '0;
      divisor[d]   = '0;
      m_i[d]       = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_state", state[d], 0);
      check("rst_in_ready", in_ready[d], 1);
      check("rst_out_valid", out_valid[d], 0);
      check("rst_quotient", quotient[d], 0);
      check("rst_remainder", remainder[d], 0);
      check("rst_div0", div0[d], 0);
      check("rst_m_o", m_o[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) run_suite(d);
    check("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
